// File: rtl/train_brake_responder_if.sv
// Brake responder signal bundle: decision inputs from the detector/speed controller
// and the registered speed/status outputs. Optional brake_events under TRAIN_BRAKE_EVENT_CNT_EN.
interface train_brake_responder_if;
  logic       brake_req;
  logic       alert;
  logic [7:0] target_speed;
  logic [7:0] cmd_speed;
  logic       brake_active;
  logic       stopped;
  logic [1:0] state;
`ifdef TRAIN_BRAKE_EVENT_CNT_EN
  logic [7:0] brake_events;

  modport master (
    output brake_req, alert, target_speed,
    input  cmd_speed, brake_active, stopped, state, brake_events
  );
  modport slave (
    input  brake_req, alert, target_speed,
    output cmd_speed, brake_active, stopped, state, brake_events
  );
`else
  modport master (
    output brake_req, alert, target_speed,
    input  cmd_speed, brake_active, stopped, state
  );
  modport slave (
    input  brake_req, alert, target_speed,
    output cmd_speed, brake_active, stopped, state
  );
`endif
endinterface

// File: rtl/train_brake_responder.sv
// Rate-limited commanded-speed generator with latched full-stop braking and a clear-hold
// before resuming. Define TRAIN_BRAKE_EVENT_CNT_EN to add the saturating brake_events counter.
module train_brake_responder #(
  parameter int unsigned DECEL_STEP = 5,
  parameter int unsigned ACCEL_STEP = 2,
  parameter int unsigned CLEAR_HOLD = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  train_brake_responder_if.slave         bus
);

  localparam int unsigned CntW = $clog2(CLEAR_HOLD + 1);
  localparam logic [7:0] DecelStep = 8'(DECEL_STEP);
  localparam logic [7:0] AccelStep = 8'(ACCEL_STEP);
  localparam logic [CntW-1:0] ClearLast = CntW'(CLEAR_HOLD - 1);

  typedef enum logic [1:0] {
    StDrive = 2'b00,
    StBrake = 2'b01,
    StHold  = 2'b10
  } state_e;

  state_e          state_q;
  logic [7:0]      speed_q;
  logic            brake_active_q;
  logic            stopped_q;
  logic [CntW-1:0] clear_cnt_q;

  logic [7:0] up_gap, dn_gap, inc, dec_drv, dec_brk, brk_speed;

  // Gaps are only consumed on the side where they cannot wrap.
  assign up_gap    = bus.target_speed - speed_q;
  assign dn_gap    = speed_q - bus.target_speed;
  assign inc       = (up_gap < AccelStep) ? up_gap : AccelStep;
  assign dec_drv   = (dn_gap < DecelStep) ? dn_gap : DecelStep;
  assign dec_brk   = (speed_q < DecelStep) ? speed_q : DecelStep;
  assign brk_speed = speed_q - dec_brk;

`ifdef TRAIN_BRAKE_EVENT_CNT_EN
  logic [7:0] events_q;
  assign bus.brake_events = events_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StDrive;
      speed_q        <= 8'd0;
      brake_active_q <= 1'b0;
      stopped_q      <= 1'b0;
      clear_cnt_q    <= '0;
`ifdef TRAIN_BRAKE_EVENT_CNT_EN
      events_q       <= 8'd0;
`endif
    end else begin
      unique case (state_q)
        StDrive: begin
          if (bus.brake_req) begin
            speed_q     <= brk_speed;
            clear_cnt_q <= '0;
`ifdef TRAIN_BRAKE_EVENT_CNT_EN
            if (events_q != 8'hff) events_q <= events_q + 8'd1;
`endif
            if (brk_speed == 8'd0) begin
              state_q   <= StHold;
              stopped_q <= 1'b1;
            end else begin
              state_q        <= StBrake;
              brake_active_q <= 1'b1;
            end
          end else if (speed_q < bus.target_speed) begin
            if (!bus.alert) speed_q <= speed_q + inc;
          end else if (speed_q > bus.target_speed) begin
            speed_q <= speed_q - dec_drv;
          end
        end
        StBrake: begin
          speed_q <= brk_speed;
          if (brk_speed == 8'd0) begin
            state_q        <= StHold;
            brake_active_q <= 1'b0;
            stopped_q      <= 1'b1;
            clear_cnt_q    <= '0;
          end
        end
        StHold: begin
          speed_q <= 8'd0;
          if (bus.brake_req) begin
            clear_cnt_q <= '0;
          end else if (clear_cnt_q >= ClearLast) begin
            state_q     <= StDrive;
            stopped_q   <= 1'b0;
            clear_cnt_q <= '0;
          end else begin
            clear_cnt_q <= clear_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q        <= StDrive;
          speed_q        <= 8'd0;
          brake_active_q <= 1'b0;
          stopped_q      <= 1'b0;
          clear_cnt_q    <= '0;
        end
      endcase
    end
  end

  assign bus.cmd_speed    = speed_q;
  assign bus.brake_active = brake_active_q;
  assign bus.stopped      = stopped_q;
  assign bus.state        = state_q;

endmodule
